zap_store_formatter: RTL and testbench
======================================

Name: zap_store_formatter

Overview:
- Store-side counterpart of the memory-stage load rotator.
- Takes store requests from the ALU/memory boundary and formats them for the data cache: sub-word data is replicated across byte lanes, byte-lane selects are generated and the address is word-aligned.
- Requests are buffered in a small FIFO with a valid/ready handshake toward the cache, so cache back-pressure does not stall the formatting logic.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- ADDR_WDT, 32, address width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_clear_from_writeback  in  1  synchronous flush of all buffered stores.
- i_valid  in  1  store request valid.
- o_ready  out  1  formatter can accept a request.
- i_address  in  ADDR_WDT  byte address of the store.
- i_data  in  32  store source value, right-justified.
- i_byte  in  1  byte store.
- i_half  in  1  halfword store.
- i_user  in  1  user-mode access attribute.
- o_valid  out  1  formatted request valid.
- i_ready  in  1  cache accepts the request.
- o_address  out  ADDR_WDT  word-aligned address; bits [1:0] always 0.
- o_data  out  32  lane-replicated store data.
- o_sel  out  4  byte-lane enables.
- o_user  out  1  user attribute.
- o_align_fault  out  1  misaligned store flag; only meaningful with the optional feature.
- o_empty  out  1  FIFO holds no entries.

Behaviour:
- Reset (asynchronous, i_reset_n low): count, read pointer and write pointer = 0; o_valid = 0; o_empty = 1; o_ready = 1; o_address, o_data, o_sel, o_user and o_align_fault = 0.
- Push: occurs when i_valid && o_ready at a clock edge.
- Pop: occurs when o_valid && i_ready at a clock edge.
- o_ready = (count != DEPTH). It is registered-state-derived and has no combinational path from i_ready.
- Latency: a pushed entry is visible on the outputs the next cycle if the FIFO was empty. Outputs always show the head entry.
- Output hold: o_valid, o_address, o_data, o_sel and o_user stay stable while o_valid && !i_ready.
- Formatting, computed before the FIFO write; a = i_address[1:0]:
  - Byte: o_data = {4{i_data[7:0]}}; o_sel = 4'b0001 << a.
  - Half: o_data = {2{i_data[15:0]}}; o_sel = a[1] ? 4'b1100 : 4'b0011.
  - Word: o_data = i_data, not rotated; o_sel = 4'b1111.
  - i_byte && i_half: treated as byte.
  - o_address = {i_address[ADDR_WDT-1:2], 2'b00} in all cases.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - Allowed when the FIFO is non-empty and not full.
  - When full, o_ready = 0, so no push occurs.
  - When empty, no pop occurs; a push makes o_valid = 1 next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. The full/empty decision uses count, 0..DEPTH.
- i_clear_from_writeback: next cycle count = 0, pointers = 0, o_valid = 0. A push or pop in the same cycle is discarded. Clear wins over everything except reset.
- Reset mid-transfer: an entry being handed to the cache is dropped; the cache must also be in reset.

Optional Feature:
- Macro: ZAP_STORE_ALIGN_CHECK_EN.
- Defined:
  - o_align_fault is stored per entry. It is 1 for a halfword store with a[0] = 1, or a word store with a != 0.
  - A faulting entry is pushed with o_sel = 4'b0000, so no bytes are written. The cache still accepts it to keep ordering.
- Undefined: o_align_fault is tied to 0 and o_sel follows the normal formatting rules.

Decomposition:
- Package zap_store_pkg:
  - typedef store_req_t: struct packed {addr, data, sel, user, align_fault}.
  - Constants for the SEL_BYTE0, SEL_HALF_LO, SEL_HALF_HI and SEL_WORD patterns.
- One sub-module, zap_store_fifo: a generic DEPTH-entry store_req_t FIFO with count, flush and asynchronous active-low reset. The top level holds the format function plus the FIFO instance.

Test Plan:
- Byte store: addr 0x1003, data 0x000000A5 -> o_address 0x1000, o_data 0xA5A5A5A5, o_sel 4'b1000, o_valid 1 cycle after accept.
- Half store: addr 0x2002, data 0xFFFF1234 -> o_data 0x12341234, o_sel 4'b1100. Word store: addr 0x2001, data 0xDEADBEEF -> o_data 0xDEADBEEF, o_sel 4'b1111, o_address 0x2000.
- Back-pressure: i_ready = 0, push 3 stores with DEPTH = 2 -> o_ready falls after the 2nd push and the 3rd is held off. Release i_ready -> entries drain in order; outputs stay stable while stalled.
- Full FIFO with i_ready = 1 and i_valid = 1 held -> one pop per cycle, o_ready returns next cycle, no loss or duplication over 16 back-to-back stores including pointer wrap.
- i_clear_from_writeback with 2 entries plus a same-cycle push -> next cycle o_valid = 0, o_empty = 1, and no entry appears afterwards.
- i_reset_n asserted mid-stall -> outputs reach their reset values immediately, without waiting for a clock edge. With ZAP_STORE_ALIGN_CHECK_EN, half store at addr 0x0001 -> o_align_fault 1, o_sel 4'b0000.

Source files
------------

// File: rtl/zap_store_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zap_store_pkg
// Purpose : Shared types and constants for the store formatter. Holds the
//           buffered store request record and the byte-lane select patterns.
// Config  : ZAP_STORE_ALIGN_CHECK_EN (used by zap_store_formatter)
// Revision: 1.0 - initial release
// ============================================================================
package zap_store_pkg;

  // Widest address the request record can carry; narrower instances
  // zero-pad the upper bits.
  localparam int ZAP_ADDR_MAX = 64;

  localparam logic [3:0] SEL_BYTE0   = 4'b0001;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  typedef struct packed {
    logic [ZAP_ADDR_MAX-1:0] addr;
    logic [31:0]             data;
    logic [3:0]              sel;
    logic                    user;
    logic                    align_fault;
  } store_req_t;

endpackage
`default_nettype wire

// File: rtl/zap_store_fifo.sv
`default_nettype none
// ============================================================================
// Module  : zap_store_fifo
// Purpose : DEPTH-entry FIFO of formatted store requests with occupancy
//           count, synchronous flush and asynchronous active-low reset.
// Ports   : i_clk, i_reset_n     - clock, async active-low reset
//           i_flush              - drop all entries (wins over push/pop)
//           i_push, i_push_data  - write request (ignored when full)
//           i_pop                - release head (ignored when empty)
//           o_ready              - not full
//           o_valid / o_empty    - head present / no entries
//           o_head               - entry at the read pointer
// Revision: 1.0 - initial release
// ============================================================================
module zap_store_fifo
  import zap_store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  store_req_t i_push_data,
  input  logic       i_pop,
  output logic       o_ready,
  output logic       o_valid,
  output logic       o_empty,
  output store_req_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  store_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             do_push;
  logic             do_pop;

  assign o_ready = (count_q != FULL_CNT);
  assign o_valid = (count_q != '0);
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_ptr_q];

  assign do_push = i_push && o_ready;
  assign do_pop  = i_pop && o_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset too so the head (and thus every output) reads as zero
  // the moment reset asserts.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/zap_store_formatter.sv
`default_nettype none
// ============================================================================
// Module  : zap_store_formatter
// Purpose : Formats store requests for the data cache (lane replication,
//           byte-lane selects, word-aligned address) and buffers them in a
//           small FIFO with a valid/ready handshake toward the cache.
// Ports   : i_clk, i_reset_n          - clock, async active-low reset
//           i_clear_from_writeback    - flush buffered stores
//           i_valid/o_ready           - request handshake (input side)
//           i_address, i_data, i_byte, i_half, i_user - store request
//           o_valid/i_ready           - request handshake (cache side)
//           o_address, o_data, o_sel, o_user, o_align_fault - head entry
//           o_empty                   - FIFO holds no entries
// Config  : `define ZAP_STORE_ALIGN_CHECK_EN to flag misaligned half/word
//           stores and suppress their byte-lane enables.
// Revision: 1.0 - initial release
// ============================================================================
module zap_store_formatter
  import zap_store_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ADDR_WDT = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear_from_writeback,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [ADDR_WDT-1:0] i_address,
  input  logic [31:0]         i_data,
  input  logic                i_byte,
  input  logic                i_half,
  input  logic                i_user,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ADDR_WDT-1:0] o_address,
  output logic [31:0]         o_data,
  output logic [3:0]          o_sel,
  output logic                o_user,
  output logic                o_align_fault,
  output logic                o_empty
);

  store_req_t fmt_req;
  store_req_t head;
  logic [1:0] offset;
  logic       push;
  logic       pop;

  assign offset = i_address[1:0];
  assign push   = i_valid && o_ready;
  assign pop    = o_valid && i_ready;

  // Byte takes priority when both size flags are set.
  always_comb begin
    fmt_req = '0;
    fmt_req.addr[ADDR_WDT-1:2] = i_address[ADDR_WDT-1:2];
    fmt_req.user = i_user;
    if (i_byte) begin
      fmt_req.data = {4{i_data[7:0]}};
      fmt_req.sel  = SEL_BYTE0 << offset;
    end else if (i_half) begin
      fmt_req.data = {2{i_data[15:0]}};
      fmt_req.sel  = offset[1] ? SEL_HALF_HI : SEL_HALF_LO;
    end else begin
      fmt_req.data = i_data;
      fmt_req.sel  = SEL_WORD;
    end
`ifdef ZAP_STORE_ALIGN_CHECK_EN
    fmt_req.align_fault = (!i_byte && i_half && offset[0]) ||
                          (!i_byte && !i_half && (offset != 2'b00));
    // Faulting stores still travel to the cache to preserve ordering, but
    // with no lanes enabled so memory is untouched.
    if (fmt_req.align_fault) begin
      fmt_req.sel = 4'b0000;
    end
`endif
  end

  zap_store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (i_clear_from_writeback),
    .i_push      (push),
    .i_push_data (fmt_req),
    .i_pop       (pop),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_empty     (o_empty),
    .o_head      (head)
  );

  assign o_address     = head.addr[ADDR_WDT-1:0];
  assign o_data        = head.data;
  assign o_sel         = head.sel;
  assign o_user        = head.user;
  // Without the alignment check the stored flag is constant zero.
  assign o_align_fault = head.align_fault;

  generate
    if (ADDR_WDT < ZAP_ADDR_MAX) begin : g_addr_pad
      logic unused_addr_hi;
      assign unused_addr_hi = ^head.addr[ZAP_ADDR_MAX-1:ADDR_WDT];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_zap_store_formatter.sv
`default_nettype none
// ============================================================================
// Module  : tb_zap_store_formatter
// Purpose : Self-checking bench for zap_store_formatter: queue-based model
//           compared every cycle plus directed literal expectations.
// Config  : honours ZAP_STORE_ALIGN_CHECK_EN
// Revision: 1.0 - initial release
// ============================================================================
module tb_zap_store_formatter;

  localparam int DEPTH    = 2;
  localparam int ADDR_WDT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        vin = 1'b0;
  logic        rdy_in = 1'b0;
  logic        byte_i = 1'b0;
  logic        half_i = 1'b0;
  logic        user_i = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;

  logic        o_ready, o_valid, o_user, o_align_fault, o_empty;
  logic [31:0] o_address, o_data;
  logic [3:0]  o_sel;

  int passed = 0;
  int total  = 0;
  int pops   = 0;
  bit chk_en = 1'b0;

  zap_store_formatter #(.DEPTH(DEPTH), .ADDR_WDT(ADDR_WDT)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_clear_from_writeback (clr),
    .i_valid                (vin),
    .o_ready                (o_ready),
    .i_address              (addr),
    .i_data                 (data),
    .i_byte                 (byte_i),
    .i_half                 (half_i),
    .i_user                 (user_i),
    .o_valid                (o_valid),
    .i_ready                (rdy_in),
    .o_address              (o_address),
    .o_data                 (o_data),
    .o_sel                  (o_sel),
    .o_user                 (o_user),
    .o_align_fault          (o_align_fault),
    .o_empty                (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        u;
    logic        f;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected cache-side view of one store, straight from the format rules.
  function automatic exp_t model_fmt(input logic [31:0] a, input logic [31:0] d,
                                     input logic b, input logic h, input logic u);
    exp_t e;
    int   off;
    off   = int'(a % 4);
    e.a   = a - (a % 4);
    e.u   = u;
    e.f   = 1'b0;
    if (b) begin
      e.d = d[7:0] * 32'h01010101;
      e.s = 4'(1 << off);
    end else if (h) begin
      e.d = d[15:0] * 32'h00010001;
      e.s = (off >= 2) ? 4'hC : 4'h3;
    end else begin
      e.d = d;
      e.s = 4'hF;
    end
`ifdef ZAP_STORE_ALIGN_CHECK_EN
    if ((!b && h && (off % 2 == 1)) || (!b && !h && off != 0)) begin
      e.f = 1'b1;
      e.s = 4'h0;
    end
`endif
    return e;
  endfunction

  // Model state update at each clock edge (and at asynchronous reset).
  always @(posedge clk or negedge rst_n) begin
    bit do_push, do_pop;
    if (!rst_n) begin
      q.delete();
    end else if (clr) begin
      q.delete();
    end else begin
      do_push = vin && (q.size() < DEPTH);
      do_pop  = (q.size() != 0) && rdy_in;
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) q.push_back(model_fmt(addr, data, byte_i, half_i, user_i));
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      chk("ready", o_ready, q.size() < DEPTH);
      chk("empty", o_empty, q.size() == 0);
      chk("valid", o_valid, q.size() != 0);
      if (q.size() != 0) begin
        e = q[0];
        chk("address", o_address, e.a);
        chk("data", o_data, e.d);
        chk("sel", o_sel, e.s);
        chk("user", o_user, e.u);
        chk("fault", o_align_fault, e.f);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] d,
                         input logic b, input logic h, input logic u);
    vin = 1'b1; addr = a; data = d; byte_i = b; half_i = h; user_i = u;
  endtask

  task automatic drain();
    vin = 1'b0;
    rdy_in = 1'b1;
    for (int k = 0; k < 20 && !o_empty; k++) cycle();
    chk("drain_empty", o_empty, 1'b1);
    rdy_in = 1'b0;
  endtask

  initial begin
    int sent;
    int base;
    bit acc;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_addr", o_address, 32'h0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_sel", o_sel, 4'h0);
    cycle();
    cycle();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Byte store, one-cycle latency.
    set_req(32'h1003, 32'h000000A5, 1'b1, 1'b0, 1'b0);
    chk("byte_not_yet", o_valid, 1'b0);
    cycle();
    vin = 1'b0;
    chk("byte_valid", o_valid, 1'b1);
    chk("byte_addr", o_address, 32'h1000);
    chk("byte_data", o_data, 32'hA5A5A5A5);
    chk("byte_sel", o_sel, 4'b1000);
    drain();

    // Half then word store.
    set_req(32'h2002, 32'hFFFF1234, 1'b0, 1'b1, 1'b1);
    cycle();
    set_req(32'h2001, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    cycle();
    vin = 1'b0;
    chk("half_data", o_data, 32'h12341234);
    chk("half_sel", o_sel, 4'b1100);
    chk("half_user", o_user, 1'b1);
    rdy_in = 1'b1;
    cycle();
    rdy_in = 1'b0;
    chk("word_data", o_data, 32'hDEADBEEF);
    chk("word_addr", o_address, 32'h2000);
`ifdef ZAP_STORE_ALIGN_CHECK_EN
    chk("word_sel", o_sel, 4'b0000);
    chk("word_fault", o_align_fault, 1'b1);
`else
    chk("word_sel", o_sel, 4'b1111);
    chk("word_fault", o_align_fault, 1'b0);
`endif
    drain();

    // Back-pressure with three requests into two entries.
    set_req(32'h3000, 32'h31, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("bp_ready1", o_ready, 1'b1);
    set_req(32'h3004, 32'h32, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("bp_ready2", o_ready, 1'b0);
    set_req(32'h3008, 32'h33, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("bp_held_data", o_data, 32'h31);
    chk("bp_held_ready", o_ready, 1'b0);
    rdy_in = 1'b1;
    cycle();
    chk("bp_ready_back", o_ready, 1'b1);
    chk("bp_second", o_data, 32'h32);
    cycle();
    vin = 1'b0;
    chk("bp_third", o_data, 32'h33);
    drain();

    // 16 back-to-back stores through a full FIFO, wrapping the pointers.
    base = pops;
    sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
      if (cyc == 2) rdy_in = 1'b1;
      set_req(32'h4000 + 32'(sent * 5), 32'hC0DE0000 | 32'(sent),
              (sent % 3) == 0, (sent % 3) == 1, sent[0]);
      acc = o_ready;
      cycle();
      if (acc) sent++;
    end
    vin = 1'b0;
    chk("stream_sent", 32'(sent), 32'd16);
    drain();
    chk("stream_pops", 32'(pops - base), 32'd16);

    // Flush with two entries plus a same-cycle push.
    set_req(32'h5000, 32'h51, 1'b0, 1'b0, 1'b0);
    cycle();
    set_req(32'h5004, 32'h52, 1'b0, 1'b0, 1'b0);
    cycle();
    set_req(32'h5008, 32'h53, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    vin = 1'b0;
    chk("clr_valid", o_valid, 1'b0);
    chk("clr_empty", o_empty, 1'b1);
    rdy_in = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("clr_stays_empty", o_valid, 1'b0);
    rdy_in = 1'b0;

    // Asynchronous reset while stalled.
    set_req(32'h6000, 32'h61, 1'b0, 1'b0, 1'b1);
    cycle();
    set_req(32'h6004, 32'h62, 1'b1, 1'b0, 1'b1);
    cycle();
    vin = 1'b0;
    user_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", o_valid, 1'b0);
    chk("mrst_empty", o_empty, 1'b1);
    chk("mrst_ready", o_ready, 1'b1);
    chk("mrst_addr", o_address, 32'h0);
    chk("mrst_data", o_data, 32'h0);
    chk("mrst_sel", o_sel, 4'h0);
    chk("mrst_user", o_user, 1'b0);
    cycle();
    rst_n = 1'b1;
    cycle();

`ifdef ZAP_STORE_ALIGN_CHECK_EN
    set_req(32'h0001, 32'h0000ABCD, 1'b0, 1'b1, 1'b0);
    cycle();
    vin = 1'b0;
    chk("align_fault", o_align_fault, 1'b1);
    chk("align_sel", o_sel, 4'b0000);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
